// File: rtl/m_dram_arbiter_pkg.sv
// Shared definitions for the DRAM port arbiter: requester indices and FSM state encoding.
package m_dram_arbiter_pkg;

    localparam int ARB_PTW = 0;
    localparam int ARB_CPU = 1;
    localparam int ARB_DMA = 2;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_WAIT  = 2'd2,
        ARB_DONE  = 2'd3
    } arb_state_e;

endpackage

// File: rtl/m_arb_prio_rr.sv
// Combinational winner selection: PTW first, then DMA when starved, else CPU/DMA round-robin.
module m_arb_prio_rr
    import m_dram_arbiter_pkg::*;
(
    input  logic [2:0] w_req,
    input  logic       last,
    input  logic       starve,
    output logic [2:0] w_win
);

    // last = 1 means the CPU won the previous CPU/DMA round, so DMA goes next.
    always_comb begin
        w_win = 3'b000;
        if (w_req[ARB_PTW]) begin
            w_win[ARB_PTW] = 1'b1;
        end else if (w_req[ARB_DMA] && (starve || last || !w_req[ARB_CPU])) begin
            w_win[ARB_DMA] = 1'b1;
        end else if (w_req[ARB_CPU]) begin
            w_win[ARB_CPU] = 1'b1;
        end
    end

endmodule

// File: rtl/m_dram_arbiter.sv
// Three-way DRAM port arbiter/sequencer: grants one requester, issues the access,
// waits for the controller's busy pulse to finish and returns data with a done pulse.
module m_dram_arbiter
    import m_dram_arbiter_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 15
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [2:0]        w_req,
    input  logic [2:0]        w_we,
    input  logic [ADDR_W-1:0] w_addr0,
    input  logic [ADDR_W-1:0] w_addr1,
    input  logic [ADDR_W-1:0] w_addr2,
    input  logic [DATA_W-1:0] w_wdata0,
    input  logic [DATA_W-1:0] w_wdata1,
    input  logic [DATA_W-1:0] w_wdata2,
    output logic [2:0]        w_done,
    output logic [DATA_W-1:0] w_rdata,
    output logic [2:0]        w_grant,
    output logic              w_dram_le,
    output logic              w_dram_we,
    output logic [ADDR_W-1:0] w_dram_addr,
    output logic [DATA_W-1:0] w_dram_wdata,
    input  logic              w_dram_busy,
    input  logic [DATA_W-1:0] w_dram_odata
);

    localparam int CNT_W = $clog2(STARVE_MAX + 1);

    arb_state_e        state_q, state_d;
    logic [2:0]        grant_q, grant_d;
    logic [2:0]        done_q, done_d;
    logic              le_q, le_d;
    logic              dwe_q, dwe_d;
    logic              last_q, last_d;
    logic              seen_q, seen_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [2:0]        win;
    logic              starve;
    logic              go;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    assign starve = (cnt_q == CNT_W'(STARVE_MAX));
    assign go     = (state_q == ARB_IDLE) && (|w_req) && !w_dram_busy;

    m_arb_prio_rr u_prio_rr (
        .w_req  (w_req),
        .last   (last_q),
        .starve (starve),
        .w_win  (win)
    );

    always_comb begin
        sel_addr  = w_addr2;
        sel_wdata = w_wdata2;
        sel_we    = w_we[ARB_DMA];
        if (win[ARB_PTW]) begin
            sel_addr  = w_addr0;
            sel_wdata = w_wdata0;
            sel_we    = w_we[ARB_PTW];
        end else if (win[ARB_CPU]) begin
            sel_addr  = w_addr1;
            sel_wdata = w_wdata1;
            sel_we    = w_we[ARB_CPU];
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= ARB_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ARB_IDLE:  if (go) state_d = ARB_ISSUE;
            ARB_ISSUE: state_d = ARB_WAIT;
            ARB_WAIT:  if (seen_q && !w_dram_busy) state_d = ARB_DONE;
            ARB_DONE:  state_d = ARB_IDLE;
            default:   state_d = ARB_IDLE;
        endcase
    end

    // Registered outputs are computed one state early so they line up with the state they belong to.
    always_comb begin
        grant_d = grant_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        last_d  = last_q;
        seen_d  = seen_q;
        cnt_d   = cnt_q;
        le_d    = 1'b0;
        dwe_d   = 1'b0;
        done_d  = 3'b000;
        case (state_q)
            ARB_IDLE: begin
                if (go) begin
                    grant_d = win;
                    addr_d  = sel_addr;
                    wdata_d = sel_wdata;
                    le_d    = !sel_we;
                    dwe_d   = sel_we;
                    if (win[ARB_DMA] || !w_req[ARB_DMA]) begin
                        cnt_d = '0;
                    end else if (win[ARB_CPU] && !starve) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ARB_ISSUE: seen_d = 1'b0;
            ARB_WAIT: begin
                if (w_dram_busy) seen_d = 1'b1;
                if (seen_q && !w_dram_busy) begin
                    rdata_d = w_dram_odata;
                    done_d  = grant_q;
                end
            end
            ARB_DONE: begin
                grant_d = 3'b000;
                if (grant_q[ARB_CPU]) begin
                    last_d = 1'b1;
                end else if (grant_q[ARB_DMA]) begin
                    last_d = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            grant_q <= '0;
            done_q  <= '0;
            le_q    <= 1'b0;
            dwe_q   <= 1'b0;
            last_q  <= 1'b0;
            seen_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            cnt_q   <= '0;
        end else begin
            grant_q <= grant_d;
            done_q  <= done_d;
            le_q    <= le_d;
            dwe_q   <= dwe_d;
            last_q  <= last_d;
            seen_q  <= seen_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            cnt_q   <= cnt_d;
        end
    end

    assign w_grant      = grant_q;
    assign w_done       = done_q;
    assign w_rdata      = rdata_q;
    assign w_dram_le    = le_q;
    assign w_dram_we    = dwe_q;
    assign w_dram_addr  = addr_q;
    assign w_dram_wdata = wdata_q;

endmodule

// File: tb/tb_m_dram_arbiter.sv
// Bench for m_dram_arbiter: directed scenarios plus a transaction-level model under random load.
module tb_m_dram_arbiter;

    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int SMAX = 2;

    logic          CLK;
    logic          RST;
    logic [2:0]    req;
    logic [2:0]    we;
    logic [AW-1:0] t_addr  [3];
    logic [DW-1:0] t_wdata [3];
    logic [2:0]    w_done;
    logic [2:0]    w_grant;
    logic [DW-1:0] w_rdata;
    logic          w_dram_le;
    logic          w_dram_we;
    logic [AW-1:0] w_dram_addr;
    logic [DW-1:0] w_dram_wdata;
    logic          dram_busy;
    logic [DW-1:0] dram_odata;

    logic          force_busy;
    logic          odata_const_en;
    logic [DW-1:0] odata_const;
    int            lat;
    int            busy_cnt;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int m_last;
    int m_starve;

    logic [2:0]    dq [$];
    logic [DW-1:0] rq [$];
    int            win_q [$];

    m_dram_arbiter #(
        .ADDR_W     (AW),
        .DATA_W     (DW),
        .STARVE_MAX (SMAX)
    ) dut (
        .CLK          (CLK),
        .RST          (RST),
        .w_req        (req),
        .w_we         (we),
        .w_addr0      (t_addr[0]),
        .w_addr1      (t_addr[1]),
        .w_addr2      (t_addr[2]),
        .w_wdata0     (t_wdata[0]),
        .w_wdata1     (t_wdata[1]),
        .w_wdata2     (t_wdata[2]),
        .w_done       (w_done),
        .w_rdata      (w_rdata),
        .w_grant      (w_grant),
        .w_dram_le    (w_dram_le),
        .w_dram_we    (w_dram_we),
        .w_dram_addr  (w_dram_addr),
        .w_dram_wdata (w_dram_wdata),
        .w_dram_busy  (dram_busy),
        .w_dram_odata (dram_odata)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [DW-1:0] mem_val(input logic [AW-1:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A3C3C;
    endfunction

    // DRAM controller model: busy for `lat` cycles starting the cycle after an issue.
    always @(posedge CLK or posedge RST) begin
        if (RST) busy_cnt <= 0;
        else if (w_dram_le || w_dram_we) busy_cnt <= lat;
        else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
    end
    assign dram_busy  = force_busy || (busy_cnt != 0);
    assign dram_odata = odata_const_en ? odata_const : mem_val(w_dram_addr);

    function automatic int pick(input logic [2:0] r);
        if (r[0]) return 0;
        if (r[1] && r[2]) return (m_starve == SMAX || m_last == 1) ? 2 : 1;
        return r[1] ? 1 : 2;
    endfunction

    task automatic tick();
        @(negedge CLK);
        cyc++;
    endtask

    task automatic do_reset();
        req = 3'b000;
        force_busy = 1'b0;
        odata_const_en = 1'b0;
        RST = 1'b1;
        tick();
        tick();
        RST = 1'b0;
    endtask

    task automatic test_reset();
        tick();
        checks++;
        if ({w_grant, w_done, w_dram_le, w_dram_we, w_dram_addr, w_dram_wdata, w_rdata} !== '0) begin
            errors++;
            $display("FAIL reset_held: grant=%b done=%b le=%b we=%b want all zero",
                     w_grant, w_done, w_dram_le, w_dram_we);
        end
        RST = 1'b0;
        tick();
        tick();
        checks++;
        if ({w_grant, w_done, w_dram_le, w_dram_we, w_dram_addr, w_dram_wdata, w_rdata} !== '0) begin
            errors++;
            $display("FAIL reset_idle: grant=%b done=%b le=%b we=%b want all zero",
                     w_grant, w_done, w_dram_le, w_dram_we);
        end
    endtask

    task automatic test_cpu_read();
        odata_const_en = 1'b1;
        odata_const = 32'hDEADBEEF;
        lat = 3;
        we = 3'b000;
        t_addr[1] = 32'h80001000;
        req = 3'b010;
        for (int k = 1; k <= 7; k++) begin
            tick();
            checks++;
            if (w_dram_le !== (k == 1) || w_dram_we !== 1'b0) begin
                errors++;
                $display("FAIL cpu_read_issue k=%0d: le=%b we=%b want le=%b we=0",
                         k, w_dram_le, w_dram_we, (k == 1));
            end
            checks++;
            if (w_done !== ((k == 6) ? 3'b010 : 3'b000)) begin
                errors++;
                $display("FAIL cpu_read_done k=%0d: got %b", k, w_done);
            end
            checks++;
            if (w_grant !== ((k <= 6) ? 3'b010 : 3'b000)) begin
                errors++;
                $display("FAIL cpu_read_grant k=%0d: got %b", k, w_grant);
            end
            if (k == 1) begin
                checks++;
                if (w_dram_addr !== 32'h80001000) begin
                    errors++;
                    $display("FAIL cpu_read_addr: got %h want 80001000", w_dram_addr);
                end
            end
            if (k == 6) begin
                checks++;
                if (w_rdata !== 32'hDEADBEEF) begin
                    errors++;
                    $display("FAIL cpu_read_rdata: got %h want deadbeef", w_rdata);
                end
                req = 3'b000;
            end
        end
        odata_const_en = 1'b0;
    endtask

    task automatic test_ptw_write();
        lat = 2;
        we = 3'b001;
        t_addr[0] = $urandom;
        t_wdata[0] = 32'h200000CF;
        req = 3'b001;
        for (int k = 1; k <= 6; k++) begin
            tick();
            checks++;
            if (w_dram_we !== (k == 1) || w_dram_le !== 1'b0) begin
                errors++;
                $display("FAIL ptw_write_issue k=%0d: we=%b le=%b want we=%b le=0",
                         k, w_dram_we, w_dram_le, (k == 1));
            end
            checks++;
            if (w_done !== ((k == 5) ? 3'b001 : 3'b000)) begin
                errors++;
                $display("FAIL ptw_write_done k=%0d: got %b", k, w_done);
            end
            if (k == 1) begin
                checks++;
                if (w_dram_wdata !== 32'h200000CF || w_dram_addr !== t_addr[0]) begin
                    errors++;
                    $display("FAIL ptw_write_data: wdata=%h addr=%h want 200000cf %h",
                             w_dram_wdata, w_dram_addr, t_addr[0]);
                end
            end
            if (k == 5) req = 3'b000;
        end
        we = 3'b000;
    endtask

    task automatic collect(input logic [2:0] r, input int l);
        dq.delete();
        rq.delete();
        lat = l;
        we = 3'b000;
        for (int i = 0; i < 3; i++) if (r[i]) t_addr[i] = $urandom;
        req = r;
        for (int k = 0; k < 80 && req != 3'b000; k++) begin
            tick();
            if (w_done != 3'b000) begin
                dq.push_back(w_done);
                rq.push_back(w_rdata);
                req = req & ~w_done;
            end
        end
        req = 3'b000;
        tick();
    endtask

    task automatic test_priority();
        logic [2:0] exp_o [2][3];
        exp_o[0] = '{3'b001, 3'b010, 3'b100};
        exp_o[1] = '{3'b001, 3'b100, 3'b010};
        do_reset();
        for (int rnd = 0; rnd < 2; rnd++) begin
            if (rnd == 1) begin
                collect(3'b010, 1);
                checks++;
                if (dq.size() != 1 || dq[0] !== 3'b010) begin
                    errors++;
                    $display("FAIL prio_cpu_only: %0d dones, first %b", dq.size(), dq[0]);
                end
            end
            collect(3'b111, 2);
            checks++;
            if (dq.size() != 3) begin
                errors++;
                $display("FAIL prio_count round %0d: got %0d dones want 3", rnd, dq.size());
            end
            for (int i = 0; i < 3 && i < dq.size(); i++) begin
                int idx;
                idx = (exp_o[rnd][i] == 3'b001) ? 0 : (exp_o[rnd][i] == 3'b010) ? 1 : 2;
                checks++;
                if (dq[i] !== exp_o[rnd][i] || rq[i] !== mem_val(t_addr[idx])) begin
                    errors++;
                    $display("FAIL prio_order round %0d #%0d: done=%b rdata=%h want %b %h",
                             rnd, i, dq[i], rq[i], exp_o[rnd][i], mem_val(t_addr[idx]));
                end
            end
        end
    endtask

    task automatic test_busy_block();
        do_reset();
        force_busy = 1'b1;
        lat = 1;
        we = 3'b000;
        t_addr[2] = $urandom;
        req = 3'b100;
        for (int k = 1; k <= 5; k++) begin
            tick();
            checks++;
            if ({w_grant, w_dram_le, w_dram_we} !== 5'b0) begin
                errors++;
                $display("FAIL busy_block k=%0d: grant=%b le=%b want 0", k, w_grant, w_dram_le);
            end
        end
        force_busy = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            tick();
            checks++;
            if (w_done !== ((k == 4) ? 3'b100 : 3'b000) || w_dram_le !== (k == 1)) begin
                errors++;
                $display("FAIL busy_release k=%0d: done=%b le=%b", k, w_done, w_dram_le);
            end
            if (k == 4) begin
                checks++;
                if (w_rdata !== mem_val(t_addr[2])) begin
                    errors++;
                    $display("FAIL busy_rdata: got %h want %h", w_rdata, mem_val(t_addr[2]));
                end
                req = 3'b000;
            end
        end
    endtask

    // Transaction-level model: mode 0 random load, 2 CPU+DMA saturated, 3 saturated plus random PTW.
    task automatic run_model(input int mode, input int ncycles);
        int free_c, issue_c, done_c, w;
        logic cur_we;
        logic [AW-1:0] cur_addr;
        logic [DW-1:0] cur_wdata;
        logic [2:0] just_done, oh, eg, ed;
        do_reset();
        m_last = 0;
        m_starve = 0;
        win_q.delete();
        free_c = cyc;
        issue_c = -10;
        done_c = -10;
        w = 0;
        cur_we = 1'b0;
        cur_addr = '0;
        cur_wdata = '0;
        for (int k = 0; k < ncycles; k++) begin
            tick();
            oh = 3'b001 << w;
            just_done = 3'b000;
            eg = (cyc >= issue_c && cyc <= done_c) ? oh : 3'b000;
            ed = (cyc == done_c) ? oh : 3'b000;
            checks++;
            if (w_grant !== eg || w_done !== ed) begin
                errors++;
                $display("FAIL model_grant_done cyc=%0d: grant=%b done=%b want %b %b",
                         cyc, w_grant, w_done, eg, ed);
            end
            checks++;
            if (w_dram_le !== (cyc == issue_c && !cur_we) ||
                w_dram_we !== (cyc == issue_c && cur_we)) begin
                errors++;
                $display("FAIL model_issue cyc=%0d: le=%b we=%b", cyc, w_dram_le, w_dram_we);
            end
            if (cyc == issue_c) begin
                checks++;
                if (w_dram_addr !== cur_addr || (cur_we && w_dram_wdata !== cur_wdata)) begin
                    errors++;
                    $display("FAIL model_latch cyc=%0d: addr=%h wdata=%h want %h %h",
                             cyc, w_dram_addr, w_dram_wdata, cur_addr, cur_wdata);
                end
            end
            if (cyc == done_c) begin
                checks++;
                if (w_rdata !== mem_val(cur_addr)) begin
                    errors++;
                    $display("FAIL model_rdata cyc=%0d: got %h want %h",
                             cyc, w_rdata, mem_val(cur_addr));
                end
                win_q.push_back(w);
                req[w] = 1'b0;
                just_done = oh;
            end
            for (int i = 0; i < 3; i++) begin
                bit want;
                if (mode == 0) want = ($urandom_range(0, 2) == 0);
                else if (i == 0) want = (mode == 3) && ($urandom_range(0, 2) == 0);
                else want = 1'b1;
                if (!req[i] && !just_done[i] && want) begin
                    t_addr[i]  = $urandom;
                    t_wdata[i] = $urandom;
                    we[i]      = 1'($urandom_range(0, 1));
                    req[i]     = 1'b1;
                end
            end
            if (cyc >= free_c && req != 3'b000) begin
                w = pick(req);
                if (w == 2 || !req[2]) m_starve = 0;
                else if (w == 1 && m_starve < SMAX) m_starve++;
                if (w == 1) m_last = 1;
                else if (w == 2) m_last = 0;
                cur_we = we[w];
                cur_addr = t_addr[w];
                cur_wdata = t_wdata[w];
                lat = $urandom_range(1, 4);
                issue_c = cyc + 1;
                done_c = cyc + lat + 3;
                free_c = done_c + 1;
            end
        end
        req = 3'b000;
    endtask

    task automatic test_alternate();
        run_model(2, 150);
        checks++;
        if (win_q.size() < 8) begin
            errors++;
            $display("FAIL alt_count: got %0d completions want >= 8", win_q.size());
        end
        for (int i = 1; i < win_q.size(); i++) begin
            checks++;
            if (win_q[i] == win_q[i-1]) begin
                errors++;
                $display("FAIL alt_order #%0d: requester %0d twice in a row", i, win_q[i]);
            end
        end
    endtask

    task automatic test_starvation();
        int run;
        run_model(3, 300);
        run = 0;
        for (int i = 0; i < win_q.size(); i++) begin
            if (win_q[i] == 1) run++;
            else if (win_q[i] == 2) run = 0;
            checks++;
            if (run > SMAX) begin
                errors++;
                $display("FAIL starve_run #%0d: %0d CPU wins without DMA want <= %0d",
                         i, run, SMAX);
            end
        end
    endtask

    task automatic test_random();
        run_model(0, 1500);
        checks++;
        if (win_q.size() < 50) begin
            errors++;
            $display("FAIL random_count: got %0d completions want >= 50", win_q.size());
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        lat = 4;
        we = 3'b000;
        t_addr[1] = $urandom;
        req = 3'b010;
        tick();
        tick();
        tick();
        #2 RST = 1'b1;
        #1;
        checks++;
        if ({w_grant, w_done, w_dram_le, w_dram_we, w_dram_addr, w_dram_wdata, w_rdata} !== '0) begin
            errors++;
            $display("FAIL reset_mid_async: grant=%b done=%b addr=%h want all zero",
                     w_grant, w_done, w_dram_addr);
        end
        req = 3'b000;
        tick();
        RST = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++;
            if (w_done !== 3'b000 || w_grant !== 3'b000) begin
                errors++;
                $display("FAIL reset_mid_quiet k=%0d: done=%b grant=%b", k, w_done, w_grant);
            end
        end
        collect(3'b010, 2);
        checks++;
        if (dq.size() != 1 || dq[0] !== 3'b010 || rq[0] !== mem_val(t_addr[1])) begin
            errors++;
            $display("FAIL reset_mid_fresh: %0d dones first=%b rdata=%h want 010 %h",
                     dq.size(), dq[0], rq[0], mem_val(t_addr[1]));
        end
    endtask

    initial begin
        RST = 1'b1;
        req = 3'b000;
        we = 3'b000;
        force_busy = 1'b0;
        odata_const_en = 1'b0;
        odata_const = '0;
        lat = 1;
        for (int i = 0; i < 3; i++) begin
            t_addr[i] = '0;
            t_wdata[i] = '0;
        end
        test_reset();
        test_cpu_read();
        test_ptw_write();
        test_priority();
        test_busy_block();
        test_alternate();
        test_starvation();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
